// File: rtl/spi_slave_rx.sv
// SPI-style slave receiver with an optional one-byte reply.
// Frames on mosi are: start bit 0, eight data bits MSB first, stop bit 1.
// A byte loaded into the TX buffer is shifted out on miso during the next frame.
module spi_slave_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock_in,
   input  logic       rs,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs,
   output logic       miso,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      DATA       = 2'd2,
      STOP       = 2'd3
   } state_t;

   state_t state;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] cs_sync;

   logic sclk_s;
   logic mosi_s;
   logic cs_s;

   logic sclk_prev;
   logic sclk_rise;
   logic mosi_bit;

   logic [2:0] bit_cnt;
   logic [7:0] rx_shift;
   logic [7:0] tx_shift;
   logic [7:0] tx_buf;
   logic       replying;

   logic start_rise;
   logic consume;
   logic load_ok;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];

   // A start bit seen while waiting opens a frame; a full buffer is consumed at that moment.
   // A load in the consume cycle is accepted because the buffer empties first.
   assign start_rise = (state == WAIT_START) && !cs_s && sclk_rise && !mosi_bit;
   assign consume    = start_rise && !tx_ready;
   assign load_ok    = tx_load && (tx_ready || consume);

   // Bring the asynchronous master lines into the clock_in domain; all lines idle high.
   always_ff @(posedge clock_in) begin
      if (rs) begin
         sclk_sync <= '1;
         mosi_sync <= '1;
         cs_sync   <= '1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      end
   end

   // Registered rising-edge pulse of sclk, with mosi delayed alongside so the sampled bit lines up.
   always_ff @(posedge clock_in) begin
      if (rs) begin
         sclk_prev <= 1'b1;
         sclk_rise <= 1'b0;
         mosi_bit  <= 1'b1;
      end else begin
         sclk_prev <= sclk_s;
         sclk_rise <= sclk_s & ~sclk_prev;
         mosi_bit  <= mosi_s;
      end
   end

   // One-byte TX buffer: tx_ready high means empty; frame start empties it, a load fills it.
   always_ff @(posedge clock_in) begin
      if (rs) begin
         tx_buf   <= 8'h00;
         tx_ready <= 1'b1;
      end else if (load_ok) begin
         tx_buf   <= tx_data;
         tx_ready <= 1'b0;
      end else if (consume) begin
         tx_ready <= 1'b1;
      end
   end

   // Frame state machine: receives the byte, drives the reply on miso, raises the result pulses.
   always_ff @(posedge clock_in) begin
      if (rs) begin
         state     <= IDLE;
         miso      <= 1'b1;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
         bit_cnt   <= 3'd0;
         rx_shift  <= 8'h00;
         tx_shift  <= 8'h00;
         replying  <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (state != IDLE && cs_s) begin
            state    <= IDLE;
            miso     <= 1'b1;
            busy     <= 1'b0;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            replying <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  miso <= 1'b1;
                  busy <= 1'b0;
                  if (!cs_s) begin
                     state <= WAIT_START;
                  end
               end
               WAIT_START: begin
                  if (start_rise) begin
                     state   <= DATA;
                     busy    <= 1'b1;
                     bit_cnt <= 3'd7;
                     if (consume) begin
                        tx_shift <= tx_buf;
                        miso     <= 1'b0;
                        replying <= 1'b1;
                     end else begin
                        miso     <= 1'b1;
                        replying <= 1'b0;
                     end
                  end
               end
               DATA: begin
                  if (sclk_rise) begin
                     rx_shift[bit_cnt] <= mosi_bit;
                     if (replying) begin
                        miso <= tx_shift[bit_cnt];
                     end
                     if (bit_cnt == 3'd0) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                     end
                  end
               end
               STOP: begin
                  if (sclk_rise) begin
                     miso     <= 1'b1;
                     busy     <= 1'b0;
                     replying <= 1'b0;
                     state    <= WAIT_START;
                     if (mosi_bit) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
